// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer for a word-organised
// data memory. Handles byte/half/word accesses, misalignment faults and
// sub-word stores by read-modify-write.
// Ports:
//   clk, rst             clock, async active-low reset
//   req_*                request channel (valid/ready, we, size, unsigned, addr, wdata, rd)
//   resp_*               response channel (valid/ready, rdata, rd, err)
//   DM_read/DM_write     data-memory strobes (never both high)
//   DM_address/DM_in     data-memory word index and write data
//   DM_out               combinational read data from the data memory
module mem_access_ctrl #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [4:0]        req_rd,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [4:0]        resp_rd,
   output logic              resp_err,
   output logic              DM_read,
   output logic              DM_write,
   output logic [ADDR_W-1:0] DM_address,
   output logic [DATA_W-1:0] DM_in,
   input  logic [DATA_W-1:0] DM_out
);

   localparam logic [1:0] SIZE_B   = 2'b00;
   localparam logic [1:0] SIZE_H   = 2'b01;
   localparam logic [1:0] SIZE_W   = 2'b10;
   localparam logic [1:0] SIZE_RSV = 2'b11;

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [1:0]          off_q, off_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                req_ready_d, resp_valid_d, resp_err_d;
   logic [DATA_W-1:0]   resp_rdata_d;
   logic [4:0]          resp_rd_d;
   logic                dm_read_d, dm_write_d;
   logic [ADDR_W-1:0]   dm_address_d;
   logic [DATA_W-1:0]   dm_in_d;
   logic [DATA_W-1:0]   lane_sh, load_ext, merged;
   logic                acc_fault;

   // Address bits above the memory's word index are ignored (address wraps).
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2]};

   function automatic logic is_fault(input logic [1:0] size, input logic [1:0] off);
      return (size == SIZE_RSV) || (size == SIZE_H && off[0]) ||
             (size == SIZE_W && off != 2'b00);
   endfunction

   assign acc_fault = is_fault(size_q, off_q);

   // Little-endian lane extraction and extension of the read word.
   always_comb begin
      lane_sh = DM_out >> {off_q, 3'b000};
      case (size_q)
         SIZE_B:  load_ext = uns_q ? {{(DATA_W-8){1'b0}}, lane_sh[7:0]}
                                   : {{(DATA_W-8){lane_sh[7]}}, lane_sh[7:0]};
         SIZE_H:  load_ext = uns_q ? {{(DATA_W-16){1'b0}}, lane_sh[15:0]}
                                   : {{(DATA_W-16){lane_sh[15]}}, lane_sh[15:0]};
         default: load_ext = DM_out;
      endcase
   end

   // Read word with the addressed sub-word lane replaced by store data.
   always_comb begin
      merged = DM_out;
      if (size_q == SIZE_B) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      else                  merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
   end

   // Next-state and next-output logic; DM drive defaults to idle each cycle.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      off_d        = off_q;
      wdata_d      = wdata_q;
      resp_valid_d = resp_valid;
      resp_rdata_d = resp_rdata;
      resp_rd_d    = resp_rd;
      resp_err_d   = resp_err;
      dm_read_d    = 1'b0;
      dm_write_d   = 1'b0;
      dm_address_d = '0;
      dm_in_d      = '0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_d      = ACCESS;
               we_d         = req_we;
               size_d       = req_size;
               uns_d        = req_unsigned;
               off_d        = req_addr[1:0];
               wdata_d      = req_wdata[15:0];
               resp_rd_d    = req_rd;
               dm_address_d = req_addr[ADDR_W+1:2];
               // Strobes are registered, so the access type is decided here.
               if (!is_fault(req_size, req_addr[1:0])) begin
                  if (req_we && req_size == SIZE_W) begin
                     dm_write_d = 1'b1;
                     dm_in_d    = req_wdata;
                  end else begin
                     dm_read_d  = 1'b1;
                  end
               end
            end
         end
         ACCESS: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = acc_fault;
            resp_rdata_d = '0;
            if (!acc_fault && !we_q) begin
               resp_rdata_d = load_ext;
            end else if (!acc_fault && we_q && size_q != SIZE_W) begin
               state_d      = MERGE;
               resp_valid_d = 1'b0;
               dm_write_d   = 1'b1;
               dm_address_d = DM_address;
               dm_in_d      = merged;
            end
         end
         MERGE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP: begin
            if (resp_ready) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         off_q      <= 2'b00;
         wdata_q    <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_rd    <= '0;
         resp_err   <= 1'b0;
         DM_read    <= 1'b0;
         DM_write   <= 1'b0;
         DM_address <= '0;
         DM_in      <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_rdata <= resp_rdata_d;
         resp_rd    <= resp_rd_d;
         resp_err   <= resp_err_d;
         DM_read    <= dm_read_d;
         DM_write   <= dm_write_d;
         DM_address <= dm_address_d;
         DM_in      <= dm_in_d;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// transactions scored against a transaction-level memory model.
module tb_mem_access_ctrl;

   localparam int unsigned ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]        req_size;
   logic [31:0]       req_addr, req_wdata;
   logic [4:0]        req_rd;
   logic              resp_valid, resp_ready, resp_err;
   logic [31:0]       resp_rdata;
   logic [4:0]        resp_rd;
   logic              DM_read, DM_write;
   logic [ADDR_W-1:0] DM_address;
   logic [31:0]       DM_in, DM_out;

   mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_rd(resp_rd), .resp_err(resp_err),
      .DM_read(DM_read), .DM_write(DM_write), .DM_address(DM_address),
      .DM_in(DM_in), .DM_out(DM_out)
   );

   always #5 clk = ~clk;

   // Data memory seen by the DUT.
   logic [31:0] mem [0:1023] = '{default: '0};
   assign DM_out = mem[DM_address];
   always @(posedge clk) if (DM_write) mem[DM_address] <= DM_in;

   // Reference model: memory contents as implied by completed requests.
   logic [31:0] ref_mem [0:1023] = '{default: '0};

   int rd_tot = 0, wr_tot = 0, both_tot = 0;
   logic [ADDR_W-1:0] last_wr_addr = '0;
   always @(negedge clk) begin
      if (DM_read)  rd_tot++;
      if (DM_write) begin wr_tot++; last_wr_addr = DM_address; end
      if (DM_read && DM_write) both_tot++;
   end

   int n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic bit ref_fault(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
   endfunction

   task automatic scramble_req();
      req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
   endtask

   task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input int hold, output logic [31:0] got);
      int idx, sh, exp_lat, exp_rd_n, exp_wr_n, lat, n, rd0, wr0;
      logic [31:0] w, m, exp_data, s_data;
      logic [4:0] s_rd;
      logic s_err;
      bit err;
      idx = int'(a[11:2]);
      sh  = 8 * int'(a[1:0]);
      w   = ref_mem[idx];
      err = ref_fault(sz, a);
      exp_data = 32'h0; exp_rd_n = 0; exp_wr_n = 0; exp_lat = 2;
      if (!err && !we) begin
         exp_rd_n = 1;
         if (sz == 2'b00) begin
            exp_data = (w >> sh) & 32'hFF;
            if (!uns && exp_data[7]) exp_data = exp_data | 32'hFFFF_FF00;
         end else if (sz == 2'b01) begin
            exp_data = (w >> sh) & 32'hFFFF;
            if (!uns && exp_data[15]) exp_data = exp_data | 32'hFFFF_0000;
         end else begin
            exp_data = w;
         end
      end else if (!err) begin
         exp_wr_n = 1;
         if (sz == 2'b10) begin
            ref_mem[idx] = wd;
         end else begin
            m = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
            ref_mem[idx] = (w & ~(m << sh)) | ((wd & m) << sh);
            exp_rd_n = 1;
            exp_lat = 3;
         end
      end

      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd; req_rd = rd;
      resp_ready = (hold == 0);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      got = 32'h0;
      if (!req_ready) begin
         check("accept_timeout", 32'(req_ready), 32'h1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      scramble_req();
      rd0 = rd_tot; wr0 = wr_tot;

      lat = 1;
      while (!resp_valid && lat < 10) begin
         @(negedge clk);
         if (!resp_valid) lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("resp_rdata", resp_rdata, exp_data);
      check("resp_err", 32'(resp_err), 32'(err));
      check("resp_rd", 32'(resp_rd), 32'(rd));
      check("ready_busy", 32'(req_ready), 32'h0);
      s_data = resp_rdata; s_rd = resp_rd; s_err = resp_err;
      got = s_data;

      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(resp_valid), 32'h1);
         check("hold_stable", {resp_rdata ^ s_data}, 32'h0);
         check("hold_rd_err", {26'h0, resp_rd, resp_err}, {26'h0, s_rd, s_err});
         check("hold_ready", 32'(req_ready), 32'h0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_valid", 32'(resp_valid), 32'h0);
      check("post_ready", 32'(req_ready), 32'h1);
      check("dm_reads", 32'(rd_tot - rd0), 32'(exp_rd_n));
      check("dm_writes", 32'(wr_tot - wr0), 32'(exp_wr_n));
   endtask

   logic [31:0] got;
   int n;

   initial begin
      rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
      req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_resp", {resp_valid, resp_err, resp_rd}, 32'h0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_dm_strobes", {DM_read, DM_write}, 32'h0);
      check("rst_dm_addr_in", 32'(DM_address) | DM_in, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 32'h1);

      // Word store then word load.
      run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1, 0, got);
      check("wr_index", 32'(last_wr_addr), 32'h4);
      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd2, 0, got);
      check("word_load", got, 32'hDEADBEEF);

      // Byte store merged into an existing word.
      run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 5'd3, 0, got);
      run_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, 5'd4, 0, got);
      run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 5'd5, 0, got);
      check("byte_merge", got, 32'h11AA3344);

      // Sign/zero extension.
      run_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h0000F080, 5'd6, 0, got);
      run_req(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 5'd7, 0, got);
      check("lb_signed", got, 32'hFFFFFF80);
      run_req(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 5'd8, 0, got);
      check("lb_unsigned", got, 32'h00000080);
      run_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 5'd9, 0, got);
      check("lh_signed", got, 32'hFFFFF080);

      // Misaligned accesses fault and leave memory alone.
      run_req(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, 5'd10, 0, got);
      check("fault_lh_data", got, 32'h0);
      run_req(1'b1, 2'b10, 1'b0, 32'h32, 32'h12345678, 5'd11, 0, got);
      run_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 5'd12, 0, got);
      check("fault_unchanged", got, 32'h0000F080);

      // Response back-pressure.
      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5'd13, 5, got);
      check("stall_load", got, 32'hDEADBEEF);

      // Randomized traffic over a small window with random high address bits.
      for (int t = 0; t < 80; t++) begin
         run_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                 ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63)),
                 $urandom, 5'($urandom), int'($urandom_range(0, 2)), got);
      end

      // Reset during the merge write of a byte store.
      run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 5'd14, 0, got);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h41; req_wdata = 32'h00000055; req_rd = 5'd15;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("rmw_read", 32'(DM_read), 32'h1);
      @(negedge clk);
      check("rmw_write", 32'(DM_write), 32'h1);
      rst = 1'b0;
      #1;
      check("abort_strobes", {DM_read, DM_write, resp_valid, req_ready}, 32'h0);
      check("abort_dm_bus", 32'(DM_address) | DM_in, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_idle", 32'(req_ready), 32'h1);
      run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 5'd16, 0, got);
      check("abort_unchanged", got, 32'hCAFEF00D);

      check("strobe_exclusive", 32'(both_tot), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, the word-index width of the data memory address.
REQ-002 The block SHALL have parameter DATA_W, default 32, the data word width; only 32 is supported.
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 Port req_valid  in  1  request present; req_ready  out  1  block can accept.
REQ-006 Port req_we  in  1  1 = store, 0 = load; req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 Port req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-008 Port req_addr  in  32  byte address; req_wdata  in  32  store data; req_rd  in  5  destination register tag.
REQ-009 Port resp_valid  out  1  response present; resp_ready  in  1  consumer accepts.
REQ-010 Port resp_rdata  out  32  extended load data; resp_rd  out  5  captured tag; resp_err  out  1  request faulted.
REQ-011 Ports DM_read  out  1, DM_write  out  1, DM_address  out  ADDR_W, DM_in  out  32: data-memory drive; DM_out  in  32: combinational read data.

Function
REQ-012 FSM states SHALL be IDLE, ACCESS, MERGE, RESP.
REQ-013 req_ready SHALL be 1 only in IDLE with rst deasserted; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-014 On acceptance, req_we, req_size, req_unsigned, req_addr, req_wdata and req_rd SHALL be captured, and the FSM SHALL go to ACCESS.
REQ-015 The fault condition SHALL be: req_size 11; half with addr[0]=1; or word with addr[1:0]!=00.
REQ-016 DM_address SHALL be captured addr[ADDR_W+1:2] in ACCESS and MERGE; higher address bits are ignored (wrap).
REQ-017 ACCESS with a fault: no DM strobe, resp_err<=1, resp_rdata<=0; next state RESP.
REQ-018 ACCESS with a load: DM_read=1.
REQ-019 Load lane selection SHALL be little-endian: byte lane addr[1:0] is bits 8k+7:8k, half lane addr[1].
REQ-020 The selected load lane SHALL be extended per req_unsigned into resp_rdata; next state RESP.
REQ-021 ACCESS with a word store: DM_write=1, DM_in=wdata; next state RESP.
REQ-022 ACCESS with a byte/half store: DM_read=1; DM_out with the addressed lane replaced by wdata[7:0] or wdata[15:0] SHALL be registered as the merge word; next state MERGE.
REQ-023 MERGE SHALL drive DM_write=1, DM_in=merge word; next state RESP.
REQ-024 Outside ACCESS/MERGE, DM_read, DM_write, DM_address and DM_in SHALL be 0; DM_read and DM_write SHALL never both be 1.
REQ-025 RESP SHALL hold resp_valid=1 with resp_rdata, resp_rd and resp_err stable until resp_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-026 Stores SHALL respond with resp_rdata=0.
REQ-027 Latency from accept edge to resp_valid SHALL be 2 cycles for load, word store and fault, and 3 cycles for sub-word store, with resp_ready held 1.
REQ-028 A new request SHALL be accepted no earlier than the cycle after the response handshake, so there is no back-to-back overlap.

Reset
REQ-029 While rst=0: state IDLE; req_ready, resp_valid, resp_err, DM_read and DM_write 0; resp_rdata, resp_rd, DM_address, DM_in and all captured/merge registers 0.
REQ-030 Reset asserted in ACCESS or MERGE SHALL abort the operation; no DM_write SHALL follow release; the first cycle after release SHALL be IDLE.

Verification
REQ-031 Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> DM_write pulse at index 4; load resp_rdata 0xDEADBEEF, resp_err 0, 2 cycles after accept.
REQ-032 Word 0x11223344 at 0x20, then byte store 0xAA at 0x22, then word load -> 0x11AA3344; store resp_valid 3 cycles after accept.
REQ-033 Word 0x0000F080 at 0x30: signed byte load 0x30 -> 0xFFFFFF80; unsigned -> 0x00000080; signed half 0x30 -> 0xFFFFF080.
REQ-034 Half load at 0x31 and word store at 0x32 -> resp_err 1, resp_rdata 0, no DM strobe; memory unchanged.
REQ-035 resp_ready held 0 for 5 cycles on a load -> resp_valid and outputs stable, req_ready 0 throughout.
REQ-036 rst pulsed low during MERGE of a byte store -> outputs zeroed immediately; target word unchanged after release.
